// File: rtl/game_state_ctrl_pkg.sv
// Shared enums and default sizes for the chess game controller.
package common_enums;

    typedef enum logic [1:0] {
        TITLE_SCREEN = 2'd0,
        SETUP_SCREEN = 2'd1,
        GAME_SCREEN  = 2'd2,
        END_SCREEN   = 2'd3
    } screen_state_t;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_SETUP = 2'd1,
        PH_PLAY  = 2'd2,
        PH_OVER  = 2'd3
    } game_phase_t;

    localparam int BOARD_DIM_DEF = 8;
    localparam int PIECE_W_DEF   = 4;

endpackage

// File: rtl/game_state_ctrl_history.sv
// Circular LIFO of committed boards used for undo. When full, a push
// overwrites the oldest entry. The top of stack is read combinationally so
// a pop and the board restore complete in the same cycle.
module board_history #(
    parameter int DEPTH  = 16,
    parameter int WORD_W = 256
) (
    input  logic                     CLOCK_50,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  logic [WORD_W-1:0]        din_i,
    output logic [WORD_W-1:0]        dout_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  top_ptr;

    assign top_ptr = wr_ptr_q - PTR_W'(1);
    assign dout_o  = mem_q[top_ptr];
    assign count_o = count_q;

    // Pointer and occupancy update; push wins over pop, clear wins over both.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (count_q != CNT_W'(DEPTH))
                count_d = count_q + CNT_W'(1);
        end else if (pop_i && (count_q != '0)) begin
            wr_ptr_d = wr_ptr_q - PTR_W'(1);
            count_d  = count_q - CNT_W'(1);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries beyond count are never observed.
    always_ff @(posedge CLOCK_50) begin
        if (push_i && !clear_i)
            mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/game_state_ctrl.sv
// Owns the committed board, side to move and game phase, with undo history.
//
//   state    | meaning
//   PH_IDLE  | after reset, waiting for the setup screen
//   PH_SETUP | committed board tracks the working board, history cleared
//   PH_PLAY  | moves commit, undos restore, time_up ends the game
//   PH_OVER  | board frozen, winner valid
module game_state_ctrl
    import common_enums::*;
#(
    parameter int BOARD_DIM  = BOARD_DIM_DEF,
    parameter int PIECE_W    = PIECE_W_DEF,
    parameter int HIST_DEPTH = 16,
    parameter int MOVE_CNT_W = 10
) (
    input  logic                                            CLOCK_50,
    input  logic                                            reset_n,
    input  screen_state_t                                   sys_state_i,
    input  logic                                            local_player_i,
    input  logic [BOARD_DIM-1:0][BOARD_DIM-1:0][PIECE_W-1:0] disp_board_i,
    input  logic                                            moved_i,
    input  logic                                            undo_i,
    input  logic                                            time_up_i,
    output logic [BOARD_DIM-1:0][BOARD_DIM-1:0][PIECE_W-1:0] stable_board_o,
    output logic                                            curr_player_o,
    output game_phase_t                                     phase_o,
    output logic [MOVE_CNT_W-1:0]                           move_count_o,
    output logic [$clog2(HIST_DEPTH):0]                     hist_count_o,
    output logic                                            winner_o,
    output logic                                            commit_ack_o,
    output logic                                            local_turn_o
);

    localparam int BOARD_BITS = BOARD_DIM * BOARD_DIM * PIECE_W;

    typedef logic [BOARD_DIM-1:0][BOARD_DIM-1:0][PIECE_W-1:0] board_t;

    board_t                  stable_q, stable_d;
    logic                    player_q, player_d;
    game_phase_t             phase_q, phase_d;
    logic [MOVE_CNT_W-1:0]   moves_q, moves_d;
    logic                    winner_q, winner_d;
    logic                    ack_q, ack_d;
    logic                    local_turn_q;
    logic                    hist_push, hist_pop, hist_clear;
    logic [BOARD_BITS-1:0]   hist_dout;
    logic [$clog2(HIST_DEPTH):0] hist_cnt;

    board_history #(
        .DEPTH  (HIST_DEPTH),
        .WORD_W (BOARD_BITS)
    ) u_hist (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .push_i   (hist_push),
        .pop_i    (hist_pop),
        .clear_i  (hist_clear),
        .din_i    (stable_q),
        .dout_o   (hist_dout),
        .count_o  (hist_cnt)
    );

    // Phase transitions and commit/undo datapath; time_up > moved > undo.
    always_comb begin
        stable_d   = stable_q;
        player_d   = player_q;
        phase_d    = phase_q;
        moves_d    = moves_q;
        winner_d   = winner_q;
        ack_d      = 1'b0;
        hist_push  = 1'b0;
        hist_pop   = 1'b0;
        hist_clear = 1'b0;
        if (sys_state_i == SETUP_SCREEN) begin
            phase_d    = PH_SETUP;
            stable_d   = disp_board_i;
            player_d   = 1'b0;
            moves_d    = '0;
            winner_d   = 1'b0;
            hist_clear = 1'b1;
        end else begin
            unique case (phase_q)
                PH_SETUP: begin
                    stable_d   = disp_board_i;
                    player_d   = 1'b0;
                    moves_d    = '0;
                    hist_clear = 1'b1;
                    if (sys_state_i == GAME_SCREEN)
                        phase_d = PH_PLAY;
                end
                PH_PLAY: begin
                    if (time_up_i) begin
                        phase_d  = PH_OVER;
                        winner_d = ~player_q;
                    end else if (moved_i) begin
                        hist_push = 1'b1;
                        stable_d  = disp_board_i;
                        player_d  = ~player_q;
                        if (moves_q != '1)
                            moves_d = moves_q + MOVE_CNT_W'(1);
                        ack_d     = 1'b1;
                    end else if (undo_i && (hist_cnt != '0)) begin
                        hist_pop = 1'b1;
                        stable_d = hist_dout;
                        player_d = ~player_q;
                        if (moves_q != '0)
                            moves_d = moves_q - MOVE_CNT_W'(1);
                        ack_d    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            stable_q     <= '0;
            player_q     <= 1'b0;
            phase_q      <= PH_IDLE;
            moves_q      <= '0;
            winner_q     <= 1'b0;
            ack_q        <= 1'b0;
            local_turn_q <= 1'b0;
        end else begin
            stable_q     <= stable_d;
            player_q     <= player_d;
            phase_q      <= phase_d;
            moves_q      <= moves_d;
            winner_q     <= winner_d;
            ack_q        <= ack_d;
            local_turn_q <= (player_d == local_player_i);
        end
    end

    assign stable_board_o = stable_q;
    assign curr_player_o  = player_q;
    assign phase_o        = phase_q;
    assign move_count_o   = moves_q;
    assign hist_count_o   = hist_cnt;
    assign winner_o       = winner_q;
    assign commit_ack_o   = ack_q;
    assign local_turn_o   = local_turn_q;

endmodule
